vecmax_msp: RTL and testbench
=============================

// Module: vecmax_msp
// PURPOSE
//  Memory-mapped MSP430 peripheral that reduces a vector of N samples to one result (max/min, signed/unsigned).
//  Software pushes samples into an input FIFO, programs length and mode, starts the reduction, then polls STATUS and reads RESULT.
//  Sits on the openMSP430 peripheral bus (per_*) and replaces the single-pair, Cin/Cout-handshaked max coprocessor.
//  Adds a FIFO, a streaming length, four modes and status flags.
// PARAMETERS
//  BASE_ADDR  14'hA0  word address of DATA; block decodes BASE_ADDR..BASE_ADDR+4
//  DW         16      sample width, 1..16; samples taken from per_din[DW-1:0]
//  DEPTH      8       input FIFO entries, power of 2, 2..64
//  LEN_W      8       width of LEN register (max vector length 2**LEN_W-1)
// PORTS
//  mclk      in   1   clock
//  puc_rst   in   1   synchronous active-high reset
//  per_addr  in   14  peripheral word address
//  per_din   in   16  write data
//  per_en    in   1   bus access enable
//  per_we    in   2   byte write enables; write = 2'b11, read = 2'b00, other values ignored
//  per_dout  out  16  read data, combinational; 16'h0 when not reading this block
// BEHAVIOUR
//  Register map (word offsets from BASE_ADDR):
//   +0 DATA    WO  push per_din[DW-1:0] into the FIFO
//   +1 CTRL    WO  bit0 START, bit1 CLEAR, bits[3:2] MODE (0 umax, 1 umin, 2 smax, 3 smin); START/CLEAR self-clear
//   +2 RESULT  RO  accumulator, zero-extended (unsigned modes) or sign-extended (signed modes) to 16 bits
//   +3 STATUS  RO  b0 BUSY, b1 DONE, b2 FULL, b3 EMPTY, b4 OVF (sticky), b[15:8] FIFO count
//   +4 LEN     RW  vector length; a read returns {0,len}
//  Reset (puc_rst=1 at a mclk edge): FIFO empty; LEN=0; MODE=0; acc=0; OVF=0; FSM=IDLE; per_dout=0.
//  FIFO push: accepted when count<DEPTH, or when a pop occurs in the same cycle. Otherwise the sample is dropped and OVF is set.
//  FSM states: IDLE -> RUN -> DONE.
//   IDLE: on a START write, load acc with the mode identity (umax 0; umin all-ones; smax most-negative; smin most-positive).
//    Load remaining=LEN and latch MODE. If LEN==0, go to DONE; else go to RUN.
//   RUN: BUSY=1. Each cycle with FIFO non-empty: pop the head, acc<=op(acc,head), remaining--.
//    When the pop makes remaining 0, go to DONE on the next edge. An empty FIFO stalls RUN without timeout.
//   DONE: DONE=1, RESULT holds the final acc.
//    A RESULT read returns acc and moves to IDLE at the next edge; DONE clears, acc is held.
//    A START write in DONE restarts exactly as from IDLE.
//  START in RUN: ignored. MODE and LEN writes in RUN: registers update, and the run in progress uses the latched values.
//  CLEAR (any state): FIFO flushed, OVF=0, acc=0, FSM=IDLE; LEN and MODE unchanged. If START and CLEAR are written together, CLEAR wins.
//  Timing: a START write at edge t makes BUSY visible after t. With k samples already queued, DONE asserts after edge t+k+1.
//  Signed compare uses DW-bit two's complement; equal values leave acc unchanged.
//  Reads of write-only addresses and of unmapped offsets return 16'h0. Reads have no side effects, except a RESULT read in DONE.
// TESTING
//  1 Reset: puc_rst 2 cycles -> STATUS=16'h0008 (EMPTY), RESULT=0, LEN=0.
//  2 umax: LEN=4, push 3,9,2,7, START mode0 -> DONE within 5 cycles, RESULT=9; RESULT read -> STATUS b1=0.
//  3 smin, DW=16: LEN=3, push 16'h0005, 16'hFFFE, 16'h8001 -> RESULT=16'h8001. smax of the same samples -> 16'h0005.
//  4 Overflow: push DEPTH+1 samples with no START -> FULL=1, OVF=1, count=DEPTH. CLEAR -> EMPTY=1, OVF=0.
//  5 Streaming: LEN=20, START with an empty FIFO, then push 20 values (max 16'h1234, one per 3 cycles) -> BUSY until last pop, RESULT=16'h1234.
//  6 Corners: START with LEN=0 in mode1 -> immediate DONE, RESULT=16'hFFFF. START during RUN ignored. puc_rst mid-RUN -> IDLE, FIFO empty.

Source files
------------

// File: rtl/vecmax_msp.sv
`default_nettype none
// ============================================================================
// Module   : vecmax_msp
// Purpose  : openMSP430 peripheral that reduces a stream of samples to a single
//            max/min result (unsigned or signed). Software pushes samples into
//            an input FIFO, sets LEN and MODE, starts a run, polls STATUS and
//            then reads RESULT.
// Ports    : mclk      - clock
//            puc_rst   - synchronous active-high reset
//            per_addr  - peripheral word address
//            per_din   - write data
//            per_en    - bus access enable
//            per_we    - byte write enables (2'b11 write, 2'b00 read)
//            per_dout  - combinational read data, zero when not selected
// Map      : +0 DATA(WO) +1 CTRL(WO) +2 RESULT(RO) +3 STATUS(RO) +4 LEN(RW)
// Revision : 1.0 - initial release
// ============================================================================
module vecmax_msp #(
    parameter logic [13:0] BASE_ADDR = 14'h00A0,
    parameter int          DW        = 16,
    parameter int          DEPTH     = 8,
    parameter int          LEN_W     = 8
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout
);

    localparam int               c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0]  c_DEPTH = c_CW'(DEPTH);

    localparam logic [2:0] c_OFF_DATA   = 3'd0;
    localparam logic [2:0] c_OFF_CTRL   = 3'd1;
    localparam logic [2:0] c_OFF_RESULT = 3'd2;
    localparam logic [2:0] c_OFF_STATUS = 3'd3;
    localparam logic [2:0] c_OFF_LEN    = 3'd4;

    // Two's complement extremes at the sample width
    localparam logic [DW-1:0] c_MOST_NEG = DW'(1) << (DW - 1);
    localparam logic [DW-1:0] c_MOST_POS = ~c_MOST_NEG;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [13:0] w_offset;
    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic        w_data_wr;
    logic        w_ctrl_wr;
    logic        w_len_wr;
    logic        w_result_rd;
    logic        w_start;
    logic        w_clear;

    assign w_offset    = per_addr - BASE_ADDR;
    // The lower-bound test stops addresses below the block from wrapping in
    assign w_hit       = (per_addr >= BASE_ADDR) && (w_offset < 14'd5);
    assign w_wr        = per_en && w_hit && (per_we == 2'b11);
    assign w_rd        = per_en && w_hit && (per_we == 2'b00);
    assign w_data_wr   = w_wr && (w_offset[2:0] == c_OFF_DATA);
    assign w_ctrl_wr   = w_wr && (w_offset[2:0] == c_OFF_CTRL);
    assign w_len_wr    = w_wr && (w_offset[2:0] == c_OFF_LEN);
    assign w_result_rd = w_rd && (w_offset[2:0] == c_OFF_RESULT);
    // CLEAR dominates START when both bits are written together
    assign w_start     = w_ctrl_wr && per_din[0] && !per_din[1];
    assign w_clear     = w_ctrl_wr && per_din[1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [c_AW-1:0]   wptr_q, wptr_d;
    logic [c_AW-1:0]   rptr_q, rptr_d;
    logic [c_CW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [1:0]        run_mode_q, run_mode_d;
    logic [1:0]        mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic              w_busy;
    logic              w_done;
    logic              w_load;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_empty;
    logic              w_full;
    logic [DW-1:0]     w_head;
    logic              w_take;
    logic [DW-1:0]     w_ident;
    logic [15:0]       w_result;
    logic [15:0]       w_status;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_DEPTH);
    assign w_head  = mem_q[rptr_q];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_load  = 1'b0;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    w_load  = 1'b1;
                    state_d = (len_q == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                // The last pop leaves remaining at zero; DONE follows one edge later
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else if (!w_empty) begin
                    w_pop = 1'b1;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (w_start) begin
                    w_load  = 1'b1;
                    state_d = (len_q == '0) ? S_DONE : S_RUN;
                end else if (w_result_rd) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (w_clear) begin
            state_d = S_IDLE;
            w_load  = 1'b0;
            w_pop   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Reduction operator and per-mode identity
    // ------------------------------------------------------------------
    always_comb begin
        w_take = 1'b0;
        case (run_mode_q)
            2'd0:    w_take = (w_head > acc_q);
            2'd1:    w_take = (w_head < acc_q);
            2'd2:    w_take = ($signed(w_head) > $signed(acc_q));
            default: w_take = ($signed(w_head) < $signed(acc_q));
        endcase
    end

    always_comb begin
        w_ident = '0;
        case (mode_d)
            2'd0:    w_ident = '0;
            2'd1:    w_ident = '1;
            2'd2:    w_ident = c_MOST_NEG;
            default: w_ident = c_MOST_POS;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    // A push into a full FIFO still fits when the head leaves in the same cycle
    assign w_push_ok = w_data_wr && (!w_full || w_pop);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        run_mode_d = run_mode_q;
        mode_d     = w_ctrl_wr ? per_din[3:2] : mode_q;
        len_d      = w_len_wr ? per_din[LEN_W-1:0] : len_q;

        if (w_clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            acc_d   = '0;
        end else begin
            if (w_push_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (w_data_wr && !w_push_ok) begin
                ovf_d = 1'b1;
            end
            if (w_load) begin
                // MODE arrives in the same CTRL write as START
                acc_d      = w_ident;
                run_mode_d = mode_d;
                rem_d      = len_q;
            end else if (w_pop) begin
                acc_d = w_take ? w_head : acc_q;
                rem_d = rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            acc_q      <= '0;
            rem_q      <= '0;
            run_mode_q <= 2'd0;
            mode_q     <= 2'd0;
            len_q      <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            run_mode_q <= run_mode_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers
    always_ff @(posedge mclk) begin
        if (w_push_ok && !w_clear) begin
            mem_q[wptr_q] <= per_din[DW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // Extension follows the mode the accumulator was built with
    assign w_result = run_mode_q[1] ? 16'($signed(acc_q)) : 16'(acc_q);
    assign w_status = {8'(count_q), 3'b000, ovf_q, w_empty, w_full, w_done, w_busy};

    always_comb begin
        per_dout = 16'h0000;
        if (w_rd) begin
            case (w_offset[2:0])
                c_OFF_RESULT: per_dout = w_result;
                c_OFF_STATUS: per_dout = w_status;
                c_OFF_LEN:    per_dout = 16'(len_q);
                default:      per_dout = 16'h0000;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vecmax_msp.sv
`default_nettype none
// ============================================================================
// Module   : tb_vecmax_msp
// Purpose  : Self-checking bench for vecmax_msp. A queue-based reference model
//            predicts every bus read; directed scenarios plus random jobs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vecmax_msp;

    localparam logic [13:0] BASE  = 14'h00A0;
    localparam int          DEPTH = 8;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    vecmax_msp #(
        .BASE_ADDR (BASE),
        .DW        (16),
        .DEPTH     (DEPTH),
        .LEN_W     (8)
    ) dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .per_addr (per_addr),
        .per_din  (per_din),
        .per_en   (per_en),
        .per_we   (per_we),
        .per_dout (per_dout)
    );

    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: FIFO as a queue, phase 0 idle / 1 running / 2 done
    // ------------------------------------------------------------------
    logic [15:0] m_q[$];
    bit          m_ovf;
    logic [7:0]  m_len;
    logic [1:0]  m_mode;
    logic [15:0] m_acc;
    int          m_rem;
    int          m_ph;

    task automatic m_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_len  = 8'd0;
        m_mode = 2'd0;
        m_acc  = 16'h0;
        m_rem  = 0;
        m_ph   = 0;
    endtask

    function automatic logic [15:0] m_ident(input logic [1:0] mode);
        case (mode)
            2'd0:    return 16'h0000;
            2'd1:    return 16'hFFFF;
            2'd2:    return 16'h8000;
            default: return 16'h7FFF;
        endcase
    endfunction

    function automatic bit m_wins(input logic [15:0] h, input logic [15:0] a, input logic [1:0] mode);
        int hv;
        int av;
        hv = mode[1] ? int'($signed(h)) : int'(h);
        av = mode[1] ? int'($signed(a)) : int'(a);
        return mode[0] ? (hv < av) : (hv > av);
    endfunction

    function automatic logic [15:0] m_read(input int off);
        logic [15:0] st;
        st = {8'(m_q.size()), 3'b000, m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH),
              (m_ph == 2), (m_ph == 1)};
        case (off)
            2:       return m_acc;
            3:       return st;
            4:       return {8'h00, m_len};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_edge(input bit en, input logic [1:0] we, input int off, input logic [15:0] din);
        bit          wr;
        bit          rd;
        bit          clr;
        bit          st;
        int          ph0;
        int          rem0;
        logic [7:0]  len0;
        logic [15:0] h;
        wr   = en && (we == 2'b11) && (off >= 0) && (off <= 4);
        rd   = en && (we == 2'b00) && (off >= 0) && (off <= 4);
        clr  = wr && (off == 1) && din[1];
        st   = wr && (off == 1) && din[0] && !din[1];
        ph0  = m_ph;
        rem0 = m_rem;
        len0 = m_len;
        if (wr && off == 4) m_len = din[7:0];
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_acc = 16'h0;
            m_ph  = 0;
        end else begin
            if (ph0 == 1 && rem0 > 0 && m_q.size() > 0) begin
                h = m_q.pop_front();
                if (m_wins(h, m_acc, m_mode)) m_acc = h;
                m_rem--;
            end
            if (wr && off == 0) begin
                if (m_q.size() < DEPTH) m_q.push_back(din);
                else m_ovf = 1'b1;
            end
            if ((ph0 == 0 || ph0 == 2) && st) begin
                m_mode = din[3:2];
                m_acc  = m_ident(din[3:2]);
                m_rem  = int'(len0);
                m_ph   = (len0 == 8'd0) ? 2 : 1;
            end else if (ph0 == 1 && rem0 == 0) begin
                m_ph = 2;
            end else if (ph0 == 2 && rd && off == 2) begin
                m_ph = 0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Bus cycle: drive at negedge, sample read data mid-cycle, step model
    // ------------------------------------------------------------------
    task automatic bus(input bit en, input logic [1:0] we, input int off, input logic [15:0] din,
                       input string tag, output logic [15:0] obs);
        per_en   = en;
        per_we   = we;
        per_addr = BASE + 14'(off);
        per_din  = din;
        #1;
        obs = per_dout;
        chk_val(tag, per_dout, (en && we == 2'b00 && off >= 0 && off <= 4) ? m_read(off) : 16'h0000);
        @(posedge mclk);
        m_edge(en, we, off, din);
        @(negedge mclk);
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic wr(input int off, input logic [15:0] d);
        logic [15:0] dummy;
        bus(1'b1, 2'b11, off, d, "dout_on_write", dummy);
    endtask

    task automatic rd(input int off, input string tag, output logic [15:0] obs);
        bus(1'b1, 2'b00, off, 16'h0, tag, obs);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        logic [15:0] s;
        cycles = 0;
        s      = 16'h0;
        while (cycles < budget) begin
            rd(3, "poll_status", s);
            cycles++;
            if (s[1]) break;
        end
        if (!s[1]) chk_val("done_timeout", s & 16'h0002, 16'h0002);
    endtask

    task automatic do_reset();
        puc_rst = 1'b1;
        per_en  = 1'b0;
        per_we  = 2'b00;
        repeat (2) @(posedge mclk);
        m_reset();
        @(negedge mclk);
        puc_rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        int          cyc;
        int          hot;
        logic [15:0] v;
        puc_rst  = 1'b1;
        per_en   = 1'b0;
        per_we   = 2'b00;
        per_addr = 14'h0;
        per_din  = 16'h0;
        m_reset();
        @(negedge mclk);

        // Reset state
        do_reset();
        rd(3, "rst_status", r);  chk_val("rst_status_const", r, 16'h0008);
        rd(2, "rst_result", r);  chk_val("rst_result_const", r, 16'h0000);
        rd(4, "rst_len", r);     chk_val("rst_len_const", r, 16'h0000);

        // Unmapped / write-only reads
        rd(0, "rd_data_wo", r);
        rd(1, "rd_ctrl_wo", r);
        rd(5, "rd_unmapped_hi", r);
        rd(-1, "rd_below_base", r);

        // umax 3,9,2,7; DONE visible on the read following edge t+5
        wr(4, 16'd4);
        wr(0, 16'd3); wr(0, 16'd9); wr(0, 16'd2); wr(0, 16'd7);
        wr(1, 16'h0001);
        wait_done(20, cyc);
        chk_val("umax_done_latency", 16'(cyc), 16'd6);
        rd(2, "umax_result", r); chk_val("umax_result_const", r, 16'd9);
        rd(3, "umax_status_after", r); chk_val("umax_done_cleared", r & 16'h0002, 16'h0000);

        // smin then smax over the same samples
        wr(4, 16'd3);
        wr(0, 16'h0005); wr(0, 16'hFFFE); wr(0, 16'h8001);
        wr(1, 16'h000D);
        wait_done(20, cyc);
        rd(2, "smin_result", r); chk_val("smin_result_const", r, 16'h8001);
        wr(0, 16'h0005); wr(0, 16'hFFFE); wr(0, 16'h8001);
        wr(1, 16'h0009);
        wait_done(20, cyc);
        rd(2, "smax_result", r); chk_val("smax_result_const", r, 16'h0005);

        // Overflow and CLEAR
        for (int i = 0; i < DEPTH + 1; i++) wr(0, 16'(i + 1));
        rd(3, "ovf_status", r);  chk_val("ovf_status_const", r, 16'h0814);
        wr(1, 16'h0003);  // START+CLEAR: CLEAR wins
        rd(3, "clear_status", r); chk_val("clear_status_const", r, 16'h0008);

        // Streaming 20 samples into an initially empty FIFO
        hot = $urandom_range(0, 19);
        wr(4, 16'd20);
        wr(1, 16'h0001);
        for (int i = 0; i < 20; i++) begin
            v = (i == hot) ? 16'h1234 : 16'($urandom_range(0, 16'h1233));
            wr(0, v);
            rd(3, "stream_status", r);
            rd(3, "stream_status", r);
        end
        wait_done(20, cyc);
        rd(2, "stream_result", r); chk_val("stream_result_const", r, 16'h1234);

        // LEN=0 in umin: immediate DONE with identity
        wr(4, 16'd0);
        wr(1, 16'h0005);
        rd(3, "len0_status", r); chk_val("len0_done", r & 16'h0002, 16'h0002);
        rd(2, "len0_result", r); chk_val("len0_result_const", r, 16'hFFFF);

        // START (with a different MODE) during RUN is ignored
        wr(4, 16'd3);
        wr(0, 16'd5);
        wr(1, 16'h0001);
        wr(1, 16'h0005);
        wr(0, 16'd100); wr(0, 16'd50);
        wait_done(20, cyc);
        rd(2, "run_start_ignored", r); chk_val("run_start_ignored_const", r, 16'd100);

        // Reset in the middle of a run
        wr(4, 16'd5);
        wr(0, 16'd1); wr(0, 16'd2);
        wr(1, 16'h0001);
        rd(3, "pre_reset_status", r);
        do_reset();
        rd(3, "midrun_reset_status", r); chk_val("midrun_reset_const", r, 16'h0008);

        // Random jobs with interleaved traffic
        for (int j = 0; j < 40; j++) begin
            int mode;
            int len;
            int pre;
            int k;
            mode = $urandom_range(0, 3);
            len  = $urandom_range(0, 12);
            pre  = $urandom_range(0, DEPTH + 1);
            if ($urandom_range(0, 7) == 0) wr(1, 16'h0002);
            wr(4, 16'(len));
            for (int i = 0; i < pre; i++) begin
                case ($urandom_range(0, 5))
                    0:       v = 16'h8000;
                    1:       v = 16'h7FFF;
                    2:       v = 16'hFFFF;
                    3:       v = 16'h0000;
                    default: v = 16'($urandom());
                endcase
                wr(0, v);
            end
            wr(1, 16'(mode << 2) | 16'h0001);
            k = 0;
            while (m_ph != 2 && k < 200) begin
                case ($urandom_range(0, 3))
                    0, 1:    wr(0, 16'($urandom()));
                    2:       rd(3, "rnd_status", r);
                    default: rd(2, "rnd_result_peek", r);
                endcase
                k++;
            end
            rd(3, "rnd_status_end", r);
            if ($urandom_range(0, 3) != 0) rd(2, "rnd_result", r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
